// File: rtl/prog_rom_loader.sv
// rtl/prog_rom_loader.sv - program memory loader and opcode fetch responder for the 8-bit CPU
module prog_rom_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_start,
  input  logic          i_load_valid,
  input  logic [7:0]    i_load_data,
  input  logic          i_load_last,
  output logic          o_load_ready,
  output logic          o_load_done,
  output logic          o_load_err,
  output logic [7:0]    o_word_count,
  output logic          o_cpu_reset,
  input  logic [AW-1:0] i_rom_address,
  output logic [7:0]    o_opcode1,
  output logic [7:0]    o_opcode2
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [7:0]    r_mem [DEPTH];
  logic          r_load_done;
  logic          r_load_err;
  logic [7:0]    r_word_count;
  logic          r_cpu_reset;
  logic [7:0]    r_opcode1;
  logic [7:0]    r_opcode2;

  logic          w_accept;
  logic          w_full;
  logic [AW-1:0] w_words;
  logic [AW-1:0] w_addr_next;

  // A restart request wins over a byte offered in the same cycle.
  assign w_accept    = (r_state == S_LOAD) && i_load_valid && !i_load_start;
  assign w_full      = &r_wr_ptr;
  // Only used when r_wr_ptr is odd, so (r_wr_ptr+1)/2 == r_wr_ptr/2 + 1.
  assign w_words     = {1'b0, r_wr_ptr[AW-1:1]} + AW'(1);
  assign w_addr_next = i_rom_address + AW'(1);

  assign o_load_ready = (r_state == S_LOAD);
  assign o_load_done  = r_load_done;
  assign o_load_err   = r_load_err;
  assign o_word_count = r_word_count;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_opcode1    = r_opcode1;
  assign o_opcode2    = r_opcode2;

  // Memory survives reset so a loaded image is kept across CPU resets.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= i_load_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_word_count <= 8'h00;
      r_cpu_reset  <= 1'b1;
      r_opcode1    <= 8'h00;
      r_opcode2    <= 8'h00;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cpu_reset <= 1'b1;
          r_opcode1   <= 8'h00;
          r_opcode2   <= 8'h00;
          if (i_load_start) begin
            r_state      <= S_LOAD;
            r_wr_ptr     <= '0;
            r_load_err   <= 1'b0;
            r_word_count <= 8'h00;
          end
        end
        S_LOAD: begin
          r_cpu_reset <= 1'b1;
          r_opcode1   <= 8'h00;
          r_opcode2   <= 8'h00;
          if (i_load_start) begin
            r_wr_ptr     <= '0;
            r_word_count <= 8'h00;
          end else if (i_load_valid) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_load_last && !r_wr_ptr[0]) begin
              r_load_err <= 1'b1;
              r_state    <= S_IDLE;
            end else if (i_load_last || w_full) begin
              r_state      <= S_RUN;
              r_load_done  <= 1'b1;
              r_word_count <= 8'(w_words);
            end
          end
        end
        S_RUN: begin
          if (i_load_start) begin
            r_state      <= S_LOAD;
            r_cpu_reset  <= 1'b1;
            r_opcode1    <= 8'h00;
            r_opcode2    <= 8'h00;
            r_wr_ptr     <= '0;
            r_load_err   <= 1'b0;
            r_word_count <= 8'h00;
          end else begin
            r_cpu_reset <= 1'b0;
            r_opcode1   <= r_mem[i_rom_address];
            r_opcode2   <= r_mem[w_addr_next];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_rom_loader.sv
// tb/tb_prog_rom_loader.sv - randomized self-checking bench for prog_rom_loader
module tb_prog_rom_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, valid, last;
  logic [7:0] data;
  logic [7:0] addr;
  logic       ready, done, err, cpu_rst;
  logic [7:0] wcnt, op1, op2;

  int n_checks = 0;
  int n_errs   = 0;

  logic [7:0] ref_mem [256];
  logic [7:0] prog    [256];

  always #5 clk = ~clk;

  prog_rom_loader #(.DEPTH(256), .AW(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_load_start(start), .i_load_valid(valid),
    .i_load_data(data), .i_load_last(last), .o_load_ready(ready),
    .o_load_done(done), .o_load_err(err), .o_word_count(wcnt),
    .o_cpu_reset(cpu_rst), .i_rom_address(addr), .o_opcode1(op1), .o_opcode2(op2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int len, input bit use_last, input int gmin, input int gmax);
    for (int i = 0; i < len; i++) begin
      int gap;
      gap = $urandom_range(gmax, gmin);
      repeat (gap) begin
        valid = 1'b0;
        last  = 1'($urandom_range(1, 0));
        data  = 8'($urandom);
        tick();
      end
      valid = 1'b1;
      data  = prog[i];
      last  = use_last && (i == len - 1);
      check("ready_in_load", ready, 1);
      tick();
      ref_mem[i] = prog[i];
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic expect_run(input int words);
    check("done_pulse", done, 1);
    check("word_count", wcnt, words);
    check("err_clear", err, 0);
    check("ready_low_run", ready, 0);
    check("cpu_rst_entry", cpu_rst, 1);
    tick();
    check("done_single", done, 0);
    check("cpu_rst_released", cpu_rst, 0);
  endtask

  task automatic fetch(input logic [7:0] a);
    logic [7:0] a1;
    a1   = a + 8'd1;
    addr = a;
    tick();
    check("opcode1", op1, ref_mem[a]);
    check("opcode2", op2, ref_mem[a1]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_op1"}, op1, 0);
    check({tag, "_op2"}, op2, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; data = 8'h00; addr = 8'h00;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_err", err, 0);
    check("reset_wcnt", wcnt, 0);
    rst = 1'b0;
    tick();

    // Basic 4-byte program.
    prog[0] = 8'h10; prog[1] = 8'h5A; prog[2] = 8'h81; prog[3] = 8'h23;
    pulse_start();
    stream(4, 1'b1, 0, 0);
    expect_run(2);
    fetch(8'd0);
    check("t1_op1_const", op1, 8'h10);
    check("t1_op2_const", op2, 8'h5A);
    fetch(8'd2);

    // Same program with 3-cycle gaps.
    pulse_start();
    check("restart_cpu_rst", cpu_rst, 1);
    stream(4, 1'b1, 3, 3);
    expect_run(2);
    fetch(8'd0);
    fetch(8'd2);

    // Odd byte count ends in error.
    prog[0] = 8'h77; prog[1] = 8'h66; prog[2] = 8'h55;
    pulse_start();
    stream(3, 1'b1, 0, 1);
    check("odd_err", err, 1);
    check_idle_outputs("odd");
    tick();
    check("odd_err_sticky", err, 1);
    check_idle_outputs("odd_later");

    // Randomized even-length programs.
    for (int it = 0; it < 6; it++) begin
      int len;
      len = 2 * $urandom_range(20, 1);
      for (int k = 0; k < len; k++) prog[k] = 8'($urandom);
      pulse_start();
      stream(len, 1'b1, 0, 2);
      expect_run(len / 2);
      for (int f = 0; f < 3; f++) fetch(8'(2 * $urandom_range(len / 2 - 1, 0)));
    end

    // Full memory without load_last.
    for (int k = 0; k < 256; k++) prog[k] = 8'(k);
    pulse_start();
    stream(256, 1'b0, 0, 0);
    expect_run(128);
    fetch(8'hFF);
    check("wrap_op1", op1, 8'hFF);
    check("wrap_op2", op2, 8'h00);
    fetch(8'h80);

    // Restart with a byte offered in the same cycle: the byte is dropped.
    prog[0] = 8'hA1; prog[1] = 8'hA2;
    pulse_start();
    stream(2, 1'b0, 0, 0);
    start = 1'b1; valid = 1'b1; data = 8'hEE;
    tick();
    start = 1'b0; valid = 1'b0;
    prog[0] = 8'h33; prog[1] = 8'h44;
    stream(2, 1'b1, 0, 0);
    expect_run(1);
    fetch(8'd0);
    fetch(8'd2);
    check("no_ee_at_2", op1, 8'h02);

    // Reload from RUN, then async reset mid-load.
    pulse_start();
    check("reload_cpu_rst", cpu_rst, 1);
    check("reload_op1", op1, 0);
    check("reload_op2", op2, 0);
    check("reload_ready", ready, 1);
    prog[0] = 8'h9C;
    stream(1, 1'b0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_wcnt", wcnt, 0);
    check("async_rst_err", err, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("held_cpu_rst", cpu_rst, 1);
    end
    prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'h56; prog[3] = 8'h78;
    pulse_start();
    stream(4, 1'b1, 0, 2);
    expect_run(2);
    fetch(8'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
